// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port ids,
// default widths.
package rv32i_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_AW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. On a tie the port that was not granted last
// wins; the history bit moves only when the owner accepts a grant.
module rr_arbiter2
    import rv32i_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_r;

    // Combinational one-hot pick from the current requests and history.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_r == PORT_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // History of the last granted port; reset favours the core on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= PORT_DBG;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant_r <= gnt[1];
        end
    end

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// Data-memory arbiter between the core load/store path (port 0) and the
// debug/loader port (port 1). One access per two cycles: ISSUE drives the
// registered memory command, RESP returns data. Illegal addresses are
// answered with an error and never reach the memory.
module rv32i_dmem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e        state_r;
    arb_state_e        state_n;
    logic [1:0]        arb_req_s;
    logic [1:0]        arb_gnt_s;
    logic              sample_s;
    logic              advance_s;
    logic              win_port_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [STRB_W-1:0] sel_wstrb_s;
    logic              sel_legal_s;
    logic              issue_ok_s;
    logic              cmd_port_r;
    logic              cmd_we_r;
    logic              cmd_err_r;
    logic              rsp_rd_r;

    assign arb_req_s  = {m1_req, m0_req};
    // Requests are only looked at in IDLE and RESP; ISSUE is a fixed slot.
    assign sample_s   = (state_r == IDLE) || (state_r == RESP);
    assign advance_s  = sample_s && (arb_gnt_s != 2'b00);
    assign win_port_s = arb_gnt_s[1];
    assign issue_ok_s = advance_s && sel_legal_s;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req_s),
        .advance (advance_s),
        .gnt     (arb_gnt_s)
    );

    // Select the winning payload and classify the address.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        sel_wstrb_s = {STRB_W{1'b0}};
        if (win_port_s == PORT_DBG) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wstrb_s = m1_wstrb;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wstrb_s = m0_wstrb;
        end
        sel_legal_s = (sel_addr_s[1:0] == 2'b00) &&
                      ((sel_addr_s >> (MEM_AW + 2)) == {ADDR_W{1'b0}});
    end

    // Next-state logic of the IDLE/ISSUE/RESP sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (advance_s) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: state_n = RESP;
            RESP: begin
                if (advance_s) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Command capture and all registered outputs (grant, memory command, response).
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {MEM_AW{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            mem_wstrb  <= {STRB_W{1'b0}};
            cmd_port_r <= 1'b0;
            cmd_we_r   <= 1'b0;
            cmd_err_r  <= 1'b0;
            rsp_rd_r   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            m0_gnt    <= advance_s && (win_port_s == PORT_CORE);
            m1_gnt    <= advance_s && (win_port_s == PORT_DBG);
            mem_en    <= issue_ok_s;
            mem_we    <= issue_ok_s && sel_we_s;
            mem_addr  <= issue_ok_s ? sel_addr_s[MEM_AW+1:2] : {MEM_AW{1'b0}};
            mem_wdata <= (issue_ok_s && sel_we_s) ? sel_wdata_s : {DATA_W{1'b0}};
            mem_wstrb <= (issue_ok_s && sel_we_s) ? sel_wstrb_s : {STRB_W{1'b0}};
            if (advance_s) begin
                cmd_port_r <= win_port_s;
                cmd_we_r   <= sel_we_s;
                cmd_err_r  <= !sel_legal_s;
            end
            m0_rvalid <= (state_r == ISSUE) && (cmd_port_r == PORT_CORE);
            m1_rvalid <= (state_r == ISSUE) && (cmd_port_r == PORT_DBG);
            m0_err    <= (state_r == ISSUE) && (cmd_port_r == PORT_CORE) && cmd_err_r;
            m1_err    <= (state_r == ISSUE) && (cmd_port_r == PORT_DBG) && cmd_err_r;
            rsp_rd_r  <= (state_r == ISSUE) && !cmd_we_r && !cmd_err_r;
            busy      <= (state_n != IDLE);
        end
    end

    // Memory read data arrives in RESP; only the owner of a legal read sees it.
    assign m0_rdata = (m0_rvalid && rsp_rd_r) ? mem_rdata : {DATA_W{1'b0}};
    assign m1_rdata = (m1_rvalid && rsp_rd_r) ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Randomised + directed bench for rv32i_dmem_arbiter with a transaction-level
// reference model and per-port response scoreboards.
module tb_rv32i_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic [3:0]  m0_wstrb = 4'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m1_wstrb = 4'h0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] ram     [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    int   checks = 0;
    int   errors = 0;
    txn_t drv0[$], drv1[$];
    rsp_t q0[$], q1[$];
    logic [31:0] last_rd0 = 32'h0;

    // model state
    int          ph = 0, last_g = 1, iss_p = 0;
    logic        e_g0, e_g1, e_en, e_we, e_rv0, e_rv1, e_busy, after_rst;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_st;

    rv32i_dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model: decides each cycle who is granted, what memory sees and
    // what the response will be; then compares the DUT just after the edge.
    always @(posedge clk) begin : model_p
        logic        s0, s1, swe, legal;
        logic [31:0] sa, swd, w;
        logic [3:0]  sst;
        int          win;
        rsp_t        r, got;
        s0 = m0_req;
        s1 = m1_req;
        if (rst) begin
            ph = 0; last_g = 1; q0.delete(); q1.delete();
            e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
            e_busy = 0; e_addr = 0; e_wd = 0; e_st = 0; after_rst = 1;
        end else begin
            after_rst = 0;
            e_rv0 = (ph == 1 && iss_p == 0);
            e_rv1 = (ph == 1 && iss_p == 1);
            e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_st = 0;
            if ((ph == 0 || ph == 2) && (s0 || s1)) begin
                if (s0 && s1) win = (last_g == 0) ? 1 : 0;
                else          win = s0 ? 0 : 1;
                last_g = win; iss_p = win; ph = 1;
                if (win == 0) begin swe = m0_we; sa = m0_addr; swd = m0_wdata; sst = m0_wstrb; e_g0 = 1; end
                else          begin swe = m1_we; sa = m1_addr; swd = m1_wdata; sst = m1_wstrb; e_g1 = 1; end
                legal = (sa % 4 == 0) && (sa < 32'd4096);
                r.err = !legal;
                r.data = 32'h0;
                if (legal) begin
                    e_en = 1; e_we = swe; e_addr = sa / 4; e_wd = swd; e_st = sst;
                    if (swe) begin
                        w = ref_mem[sa / 4];
                        for (int b = 0; b < 4; b++)
                            if (sst[b]) w[8*b +: 8] = swd[8*b +: 8];
                        ref_mem[sa / 4] = w;
                    end else begin
                        r.data = ref_mem[sa / 4];
                    end
                end
                if (win == 0) q0.push_back(r); else q1.push_back(r);
            end else if (ph == 1) begin
                ph = 2;
            end else begin
                ph = 0;
            end
            e_busy = (ph != 0);
        end
        #1;
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("mem_en", mem_en, e_en);
        chk("busy", busy, e_busy);
        chk("m0_rvalid_timing", m0_rvalid, e_rv0);
        chk("m1_rvalid_timing", m1_rvalid, e_rv1);
        if (e_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", 32'(mem_addr), e_addr);
            if (e_we) begin
                chk("mem_wdata", mem_wdata, e_wd);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_st));
            end
        end
        if (after_rst) begin
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        end
        if (m0_rvalid === 1'b1) begin
            if (q0.size() == 0) chk("m0_rvalid_orphan", m0_rvalid, 1'b0);
            else begin
                got = q0.pop_front();
                chk("m0_rdata", m0_rdata, got.data);
                chk("m0_err", m0_err, got.err);
                last_rd0 = m0_rdata;
            end
        end else begin
            chk("m0_rdata_idle", m0_rdata, 32'h0);
            chk("m0_err_idle", m0_err, 1'b0);
        end
        if (m1_rvalid === 1'b1) begin
            if (q1.size() == 0) chk("m1_rvalid_orphan", m1_rvalid, 1'b0);
            else begin
                got = q1.pop_front();
                chk("m1_rdata", m1_rdata, got.data);
                chk("m1_err", m1_err, got.err);
            end
        end else begin
            chk("m1_rdata_idle", m1_rdata, 32'h0);
            chk("m1_err_idle", m1_err, 1'b0);
        end
    end

    function automatic txn_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] st);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.wstrb = st;
        return t;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) * 32'd4;
        if (k == 0) a = a + 32'($urandom_range(1, 3));
        if (k == 1) a = a + 32'h1000 * 32'($urandom_range(1, 8));
        if (k == 2) a = a | 32'h8000_0000;
        return a;
    endfunction

    task automatic present(input int p, input txn_t t);
        if (p == 0) begin m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb; m0_req = 1'b1; end
        else        begin m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb; m1_req = 1'b1; end
    endtask

    // Drive both requester queues to completion; gap_pct inserts idle cycles.
    task automatic run_queues(input int gap_pct, input int max_cyc);
        int cyc = 0;
        while ((drv0.size() > 0 || drv1.size() > 0 || m0_req || m1_req) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (m0_req && m0_gnt) begin void'(drv0.pop_front()); m0_req = 1'b0; end
            if (m1_req && m1_gnt) begin void'(drv1.pop_front()); m1_req = 1'b0; end
            if (!m0_req && drv0.size() > 0 && $urandom_range(99) >= gap_pct) present(0, drv0[0]);
            if (!m1_req && drv1.size() > 0 && $urandom_range(99) >= gap_pct) present(1, drv1[0]);
        end
        chk("run_timeout", 32'(cyc >= max_cyc), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // continuous reads on both ports: alternation starting with port 0
        for (int i = 0; i < 3; i++) begin
            drv0.push_back(mk(1'b0, 32'(8 * i), 32'h0, 4'h0));
            drv1.push_back(mk(1'b0, 32'(8 * i + 4), 32'h0, 4'h0));
        end
        run_queues(0, 200);

        // port 1 writes, port 0 reads back
        drv1.push_back(mk(1'b1, 32'h0, 32'h0000_000F, 4'hF));
        run_queues(0, 100);
        drv0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
        run_queues(0, 100);
        chk("wr_rd_data", last_rd0, 32'h0000_000F);

        // misaligned and out-of-range reads
        drv0.push_back(mk(1'b0, 32'h0000_0002, 32'h0, 4'h0));
        drv0.push_back(mk(1'b0, 32'h0000_1000, 32'h0, 4'h0));
        run_queues(0, 100);

        // byte-lane write over a preloaded word
        drv1.push_back(mk(1'b1, 32'h10, 32'h1122_3344, 4'hF));
        drv1.push_back(mk(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0010));
        run_queues(0, 100);
        drv0.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        run_queues(0, 100);
        chk("byte_lane_data", last_rd0, 32'h1122_CC44);

        // reset during the ISSUE cycle of a port 0 read
        present(0, mk(1'b0, 32'h10, 32'h0, 4'h0));
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_gnt && n < 20);
        chk("rst_issue_gnt_seen", m0_gnt, 1'b1);
        m0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        drv0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
        drv1.push_back(mk(1'b0, 32'h4, 32'h0, 4'h0));
        run_queues(0, 100);

        // idle
        repeat (10) @(negedge clk);

        // randomised traffic
        for (int i = 0; i < 40; i++) begin
            drv0.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15))));
            drv1.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15))));
        end
        run_queues(30, 2000);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
